// File: rtl/ec1_run_ctrl.sv
// Run/step/breakpoint sequencer for the EC-1 core: turns button requests into a
// one-clock cpu_ce on the board clock and tracks the number of issued instruction cycles.
module ec1_run_ctrl #(
    parameter int unsigned DIV   = 100_000_000,
    parameter int unsigned CNT_W = 27,
    parameter int unsigned PC_W  = 4
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            run_btn,
    input  logic            step_btn,
    input  logic            stop_btn,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    input  logic            H,
    output logic            cpu_ce,
    output logic [1:0]      state,
    output logic [15:0]     cycle_cnt
);

    localparam int unsigned CC_W     = 16;
    localparam int unsigned NB       = 3;
    localparam int unsigned BTN_RUN  = 0;
    localparam int unsigned BTN_STEP = 1;
    localparam int unsigned BTN_STOP = 2;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);
    localparam logic [CC_W-1:0]  CC_MAX    = '1;

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic             skip_bp_q, skip_bp_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic [CC_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [NB-1:0]    btn_m_q, btn_m_d;
    logic [NB-1:0]    btn_s1_q, btn_s1_d;
    logic [NB-1:0]    btn_s2_q, btn_s2_d;
    logic [NB-1:0]    btn_ev;
    logic             ev_run, ev_step, ev_stop;
    logic             bp_hit;

    // Two-flop synchroniser plus edge flop; one event per press.
    always_comb begin
        btn_m_d  = {stop_btn, step_btn, run_btn};
        btn_s1_d = btn_m_q;
        btn_s2_d = btn_s1_q;
        btn_ev   = btn_s1_q & ~btn_s2_q;
    end

    assign ev_run  = btn_ev[BTN_RUN];
    assign ev_step = btn_ev[BTN_STEP];
    assign ev_stop = btn_ev[BTN_STOP];
    assign bp_hit  = bp_en && (pc == bp_addr) && !skip_bp_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_STOP;
            tick_q      <= '0;
            skip_bp_q   <= 1'b0;
            cpu_ce_q    <= 1'b0;
            cycle_cnt_q <= '0;
            btn_m_q     <= '0;
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            skip_bp_q   <= skip_bp_d;
            cpu_ce_q    <= cpu_ce_d;
            cycle_cnt_q <= cycle_cnt_d;
            btn_m_q     <= btn_m_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
        end
    end

    // Next state; halt outranks every button, stop outranks step outranks run.
    always_comb begin
        state_d     = state_q;
        tick_d      = '0;
        skip_bp_d   = skip_bp_q;
        cpu_ce_d    = 1'b0;
        cycle_cnt_d = cycle_cnt_q;

        if (cpu_ce_q && (cycle_cnt_q != CC_MAX)) begin
            cycle_cnt_d = cycle_cnt_q + CC_W'(1);
        end

        if (state_q != ST_HALT && H) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (!ev_stop) begin
                        if (ev_step) begin
                            state_d  = ST_STEP;
                            cpu_ce_d = 1'b1;
                        end else if (ev_run) begin
                            state_d   = ST_RUN;
                            skip_bp_d = 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    state_d = ST_STOP;
                end
                ST_RUN: begin
                    if (ev_stop) begin
                        state_d = ST_STOP;
                    end else if (tick_q == TICK_LAST) begin
                        // skip_bp lets a resumed run step off the breakpoint PC once.
                        if (bp_hit) begin
                            state_d = ST_STOP;
                        end else begin
                            cpu_ce_d  = 1'b1;
                            skip_bp_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + CNT_W'(1);
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
